// File: rtl/cma_host_pkg.sv
// Shared encodings and default widths for the CMA host-side sequencer.
// Defaults match the CMA external-port widths.
package cma_host_pkg;

    localparam int          DEF_DATA_W  = 32;
    localparam int          DEF_EXA_W   = 16;
    localparam int          DEF_ROMUL_W = 2;
    localparam int          DEF_BANK_W  = 1;
    localparam int          DEF_RD_LAT  = 2;
    localparam int          DEF_CNT_W   = 24;
    localparam int unsigned DEF_TIMEOUT = 32'd1 << 20;

    // Read-latency counter only needs to reach 7
    localparam int LAT_W = 3;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_RUN   = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RSP,
        S_RUN
    } state_e;

endpackage

// File: rtl/cma_host_ctrl_if.sv
// Command/response stream plus CMA external bus, bundled for the host sequencer.
// The master modport is the sequencer's view; slave is the host/array side.
interface cma_host_ctrl_if
    import cma_host_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int EXA_W   = DEF_EXA_W,
    parameter int ROMUL_W = DEF_ROMUL_W,
    parameter int BANK_W  = DEF_BANK_W
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [EXA_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]  cmd_data;
    logic [ROMUL_W-1:0] cmd_romul;
    logic [BANK_W-1:0]  cmd_bank;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_data;

    logic [EXA_W-1:0]   exa;
    logic [DATA_W-1:0]  exwd;
    logic [ROMUL_W-1:0] exromul;
    logic               exwe;
    logic               exre;
    logic [DATA_W-1:0]  exrd;
    logic [BANK_W-1:0]  cbank;
    logic               run;
    logic               done;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_romul, cmd_bank,
        input  rsp_ready, exrd, done,
        output cmd_ready, rsp_valid, rsp_data,
        output exa, exwd, exromul, exwe, exre, cbank, run
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_romul, cmd_bank,
        output rsp_ready, exrd, done,
        input  cmd_ready, rsp_valid, rsp_data,
        input  exa, exwd, exromul, exwe, exre, cbank, run
    );

endinterface

// File: rtl/cma_host_ctrl_watchdog.sv
// Run-cycle counter for RUN commands: saturating count, timeout compare, sticky error.
// expire is combinational so the sequencer drops run on the same edge the limit is reached.
module cma_run_watchdog
    import cma_host_pkg::*;
#(
    parameter int          CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             active,
    input  logic             done,
    output logic [CNT_W-1:0] count,
    output logic             expire,
    output logic             timeout_err
);

    logic [CNT_W:0] count_inc;
    logic           hit;

    // done on the limiting cycle takes priority, so no expiry then
    always_comb begin
        count_inc = {1'b0, count} + (CNT_W + 1)'(1);
        hit       = (TIMEOUT != 0) && (64'(count_inc) >= 64'(TIMEOUT));
        expire    = active && hit && !done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            timeout_err <= 1'b0;
        end else if (start) begin
            count       <= '0;
            timeout_err <= 1'b0;
        end else if (active) begin
            if (!count_inc[CNT_W]) begin
                count <= count_inc[CNT_W-1:0];
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cma_host_ctrl.sv
// Host-side sequencer turning WRITE/READ/RUN commands into CMA external-bus cycles.
// Every output is a flop; the next-state process computes next output values.
module cma_host_ctrl
    import cma_host_pkg::*;
#(
    parameter int          DATA_W  = DEF_DATA_W,
    parameter int          EXA_W   = DEF_EXA_W,
    parameter int          ROMUL_W = DEF_ROMUL_W,
    parameter int          BANK_W  = DEF_BANK_W,
    parameter int          RD_LAT  = DEF_RD_LAT,
    parameter int          CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    cma_host_ctrl_if.master   bus,
    output logic              busy,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              timeout_err
);

    state_e             state, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               exwe_q, exwe_d;
    logic               exre_q, exre_d;
    logic               run_q, run_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               busy_q;
    logic [EXA_W-1:0]   exa_q, exa_d;
    logic [DATA_W-1:0]  exwd_q, exwd_d;
    logic [ROMUL_W-1:0] exromul_q, exromul_d;
    logic [BANK_W-1:0]  cbank_q, cbank_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               wd_start;
    logic               wd_expire;

    cma_run_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .start       (wd_start),
        .active      (run_q),
        .done        (bus.done),
        .count       (run_cycles),
        .expire      (wd_expire),
        .timeout_err (timeout_err)
    );

    always_comb begin
        state_d     = state;
        exa_d       = exa_q;
        exwd_d      = exwd_q;
        exromul_d   = exromul_q;
        cbank_d     = cbank_q;
        rsp_data_d  = rsp_data_q;
        lat_d       = lat_q;
        exwe_d      = 1'b0;
        exre_d      = 1'b0;
        run_d       = 1'b0;
        rsp_valid_d = 1'b0;
        wd_start    = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_ready_q && bus.cmd_valid) begin
                    case (op_e'(bus.cmd_op))
                        OP_WRITE: begin
                            state_d   = S_WR;
                            exwe_d    = 1'b1;
                            exa_d     = bus.cmd_addr;
                            exwd_d    = bus.cmd_data;
                            exromul_d = bus.cmd_romul;
                        end
                        OP_READ: begin
                            state_d   = S_RD;
                            exre_d    = 1'b1;
                            exa_d     = bus.cmd_addr;
                            exromul_d = bus.cmd_romul;
                            lat_d     = LAT_W'(1);
                        end
                        OP_RUN: begin
                            state_d  = S_RUN;
                            run_d    = 1'b1;
                            cbank_d  = bus.cmd_bank;
                            wd_start = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_WR: state_d = S_IDLE;
            // lat_q counts cycles since exre rose; exrd is valid on the RD_LAT-th
            S_RD: begin
                if (lat_q == LAT_W'(RD_LAT)) begin
                    rsp_data_d  = bus.exrd;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_RSP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            S_RUN: begin
                if (bus.done || wd_expire) begin
                    state_d = S_IDLE;
                end else begin
                    run_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_ready_q <= 1'b0;
            exwe_q      <= 1'b0;
            exre_q      <= 1'b0;
            run_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            exa_q       <= '0;
            exwd_q      <= '0;
            exromul_q   <= '0;
            cbank_q     <= '0;
            rsp_data_q  <= '0;
            lat_q       <= '0;
        end else begin
            state       <= state_d;
            cmd_ready_q <= cmd_ready_d;
            exwe_q      <= exwe_d;
            exre_q      <= exre_d;
            run_q       <= run_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= (state_d != S_IDLE);
            exa_q       <= exa_d;
            exwd_q      <= exwd_d;
            exromul_q   <= exromul_d;
            cbank_q     <= cbank_d;
            rsp_data_q  <= rsp_data_d;
            lat_q       <= lat_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.exa       = exa_q;
    assign bus.exwd      = exwd_q;
    assign bus.exromul   = exromul_q;
    assign bus.exwe      = exwe_q;
    assign bus.exre      = exre_q;
    assign bus.cbank     = cbank_q;
    assign bus.run       = run_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_cma_host_ctrl.sv
// Directed bench for cma_host_ctrl: default instance plus a TIMEOUT=50 instance.
// A one-register array model returns rd_val exactly RD_LAT=2 cycles after exre.
module tb_cma_host_ctrl;
    import cma_host_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cma_host_ctrl_if bus ();
    cma_host_ctrl_if bus_to ();

    logic        busy, busy_to, timeout_err, timeout_err_to;
    logic [23:0] run_cycles, run_cycles_to;
    logic        re_d = 1'b0;
    logic [31:0] rd_val = 32'h0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) re_d <= bus.exre;
    assign bus.exrd    = re_d ? rd_val : 32'hBAD0_BAD0;
    assign bus_to.exrd = 32'h0;

    cma_host_ctrl dut (
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .run_cycles(run_cycles), .timeout_err(timeout_err)
    );

    cma_host_ctrl #(.TIMEOUT(50)) dut_to (
        .clk(clk), .rst(rst), .bus(bus_to),
        .busy(busy_to), .run_cycles(run_cycles_to), .timeout_err(timeout_err_to)
    );

    // Called just after a negedge; returns at the negedge one cycle after acceptance
    task automatic send_cmd(input bit to, input logic [1:0] op, input logic [15:0] addr,
                            input logic [31:0] data, input logic [1:0] romul, input logic bank);
        total++;
        if (to) begin
            if (bus_to.cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL send_ready_to: got %b want 1", bus_to.cmd_ready); end
            bus_to.cmd_valid = 1'b1; bus_to.cmd_op = op; bus_to.cmd_addr = addr;
            bus_to.cmd_data = data; bus_to.cmd_romul = romul; bus_to.cmd_bank = bank;
        end else begin
            if (bus.cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL send_ready: got %b want 1", bus.cmd_ready); end
            bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr;
            bus.cmd_data = data; bus.cmd_romul = romul; bus.cmd_bank = bank;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus_to.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_cmd_ready: got %b want 0", bus.cmd_ready); end
        total++; if (bus.run !== 1'b0) begin bad++; $display("[TB] FAIL rst_run: got %b want 0", bus.run); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        total++; if (run_cycles !== 24'd0) begin bad++; $display("[TB] FAIL rst_run_cycles: got %0d want 0", run_cycles); end
        total++; if (bus.exa !== 16'h0) begin bad++; $display("[TB] FAIL rst_exa: got %h want 0", bus.exa); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready_after: got %b want 1", bus.cmd_ready); end
        total++; if (bus_to.cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready_after_to: got %b want 1", bus_to.cmd_ready); end
    endtask

    task automatic test_write();
        send_cmd(0, OP_WRITE, 16'h0010, 32'hDEADBEEF, 2'd1, 1'b0);
        total++; if (bus.exwe !== 1'b1) begin bad++; $display("[TB] FAIL wr_exwe: got %b want 1", bus.exwe); end
        total++; if (bus.exa !== 16'h0010) begin bad++; $display("[TB] FAIL wr_exa: got %h want 0010", bus.exa); end
        total++; if (bus.exwd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL wr_exwd: got %h want deadbeef", bus.exwd); end
        total++; if (bus.exromul !== 2'd1) begin bad++; $display("[TB] FAIL wr_exromul: got %0d want 1", bus.exromul); end
        total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL wr_cmd_ready: got %b want 0", bus.cmd_ready); end
        total++; if ({bus.exre, bus.run} !== 2'b00) begin bad++; $display("[TB] FAIL wr_exclusive: got %b want 00", {bus.exre, bus.run}); end
        @(negedge clk);
        total++; if (bus.exwe !== 1'b0) begin bad++; $display("[TB] FAIL wr_exwe_one_cycle: got %b want 0", bus.exwe); end
        // back-to-back: second write accepted at edge N+2
        send_cmd(0, OP_WRITE, 16'h0011, 32'h0BADCAFE, 2'd2, 1'b0);
        total++; if (bus.exwe !== 1'b1 || bus.exa !== 16'h0011) begin bad++; $display("[TB] FAIL b2b_write: got exwe=%b exa=%h want 1 0011", bus.exwe, bus.exa); end
        total++; if (bus.exwd !== 32'h0BADCAFE) begin bad++; $display("[TB] FAIL b2b_exwd: got %h want 0badcafe", bus.exwd); end
        @(negedge clk);
    endtask

    task automatic test_read();
        rd_val = 32'h12345678;
        send_cmd(0, OP_READ, 16'h0020, 32'h0, 2'd2, 1'b0);
        total++; if (bus.exre !== 1'b1) begin bad++; $display("[TB] FAIL rd_exre: got %b want 1", bus.exre); end
        total++; if (bus.exa !== 16'h0020 || bus.exromul !== 2'd2) begin bad++; $display("[TB] FAIL rd_addr: got %h/%0d want 0020/2", bus.exa, bus.exromul); end
        @(negedge clk);
        total++; if (bus.exre !== 1'b0) begin bad++; $display("[TB] FAIL rd_exre_one_cycle: got %b want 0", bus.exre); end
        total++; if (bus.exa !== 16'h0020) begin bad++; $display("[TB] FAIL rd_exa_held: got %h want 0020", bus.exa); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_rsp_early: got %b want 0", bus.rsp_valid); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("[TB] FAIL rsp_valid_hold%0d: got %b want 1", i, bus.rsp_valid); end
            total++; if (bus.rsp_data !== 32'h12345678) begin bad++; $display("[TB] FAIL rsp_data_hold%0d: got %h want 12345678", i, bus.rsp_data); end
            total++; if (bus.cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL rsp_cmd_ready%0d: got %b want 0", i, bus.cmd_ready); end
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rsp_drop: got %b want 0", bus.rsp_valid); end
        total++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rsp_idle: got ready=%b busy=%b want 1 0", bus.cmd_ready, busy); end
    endtask

    task automatic test_reserved();
        send_cmd(0, OP_RSVD, 16'h00FF, 32'h1, 2'd3, 1'b1);
        total++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rsvd_idle: got ready=%b busy=%b want 1 0", bus.cmd_ready, busy); end
        total++; if ({bus.exwe, bus.exre, bus.run} !== 3'b000) begin bad++; $display("[TB] FAIL rsvd_bus: got %b want 000", {bus.exwe, bus.exre, bus.run}); end
    endtask

    task automatic test_run();
        int hi = 0;
        send_cmd(0, OP_RUN, 16'h0, 32'h0, 2'd0, 1'b1);
        total++; if (bus.cbank !== 1'b1) begin bad++; $display("[TB] FAIL run_cbank: got %b want 1", bus.cbank); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL run_busy: got %b want 1", busy); end
        for (int i = 1; i <= 100; i++) begin
            if (bus.run === 1'b1) hi++;
            if (i == 100) bus.done = 1'b1;
            @(negedge clk);
        end
        bus.done = 1'b0;
        total++; if (hi != 100) begin bad++; $display("[TB] FAIL run_high_cycles: got %0d want 100", hi); end
        total++; if (bus.run !== 1'b0) begin bad++; $display("[TB] FAIL run_drop: got %b want 0", bus.run); end
        total++; if (run_cycles !== 24'd100) begin bad++; $display("[TB] FAIL run_cycles: got %0d want 100", run_cycles); end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL run_no_err: got %b want 0", timeout_err); end
        total++; if (bus.cbank !== 1'b1 || bus.cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL run_after: got cbank=%b ready=%b want 1 1", bus.cbank, bus.cmd_ready); end
    endtask

    task automatic test_spurious_done();
        bus.done = 1'b1;
        repeat (3) @(negedge clk);
        bus.done = 1'b0;
        total++; if (busy !== 1'b0 || bus.run !== 1'b0) begin bad++; $display("[TB] FAIL spur_state: got busy=%b run=%b want 0 0", busy, bus.run); end
        total++; if (run_cycles !== 24'd100) begin bad++; $display("[TB] FAIL spur_cycles: got %0d want 100", run_cycles); end
        total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL spur_ready: got %b want 1", bus.cmd_ready); end
    endtask

    task automatic test_timeout();
        int hi = 0;
        send_cmd(1, OP_RUN, 16'h0, 32'h0, 2'd0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (bus_to.run === 1'b1) hi++;
            @(negedge clk);
        end
        total++; if (hi != 50) begin bad++; $display("[TB] FAIL to_high_cycles: got %0d want 50", hi); end
        total++; if (timeout_err_to !== 1'b1) begin bad++; $display("[TB] FAIL to_err: got %b want 1", timeout_err_to); end
        total++; if (run_cycles_to !== 24'd50) begin bad++; $display("[TB] FAIL to_cycles: got %0d want 50", run_cycles_to); end
        total++; if (bus_to.cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL to_ready: got %b want 1", bus_to.cmd_ready); end
        send_cmd(1, OP_RUN, 16'h0, 32'h0, 2'd0, 1'b0);
        total++; if (timeout_err_to !== 1'b0) begin bad++; $display("[TB] FAIL to_err_cleared: got %b want 0", timeout_err_to); end
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) bus_to.done = 1'b1;
            @(negedge clk);
        end
        bus_to.done = 1'b0;
        total++; if (run_cycles_to !== 24'd10 || bus_to.run !== 1'b0) begin bad++; $display("[TB] FAIL to_rerun: got cycles=%0d run=%b want 10 0", run_cycles_to, bus_to.run); end
    endtask

    task automatic test_done_on_timeout();
        send_cmd(1, OP_RUN, 16'h0, 32'h0, 2'd0, 1'b1);
        for (int i = 1; i <= 50; i++) begin
            if (i == 50) bus_to.done = 1'b1;
            @(negedge clk);
        end
        bus_to.done = 1'b0;
        total++; if (timeout_err_to !== 1'b0) begin bad++; $display("[TB] FAIL dot_err: got %b want 0", timeout_err_to); end
        total++; if (run_cycles_to !== 24'd50 || bus_to.run !== 1'b0) begin bad++; $display("[TB] FAIL dot_state: got cycles=%0d run=%b want 50 0", run_cycles_to, bus_to.run); end
        total++; if (bus_to.cbank !== 1'b1) begin bad++; $display("[TB] FAIL dot_cbank: got %b want 1", bus_to.cbank); end
    endtask

    task automatic test_reset_mid();
        send_cmd(0, OP_RUN, 16'h0, 32'h0, 2'd0, 1'b1);
        repeat (4) @(negedge clk);
        total++; if (bus.run !== 1'b1) begin bad++; $display("[TB] FAIL mid_run_active: got %b want 1", bus.run); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.run !== 1'b0 || bus.cbank !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_run_rst: got run=%b cbank=%b busy=%b want 0 0 0", bus.run, bus.cbank, busy); end
        total++; if (run_cycles !== 24'd0 || bus.cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_run_rst2: got cycles=%0d ready=%b want 0 0", run_cycles, bus.cmd_ready); end
        rst = 1'b0;
        @(negedge clk);
        rd_val = 32'hCAFEF00D;
        send_cmd(0, OP_READ, 16'h0030, 32'h0, 2'd1, 1'b0);
        repeat (2) @(negedge clk);
        total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL mid_rsp_pre: got v=%b d=%h want 1 cafef00d", bus.rsp_valid, bus.rsp_data); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0 || bus.exa !== 16'h0) begin bad++; $display("[TB] FAIL mid_rsp_rst: got v=%b d=%h a=%h want 0 0 0", bus.rsp_valid, bus.rsp_data, bus.exa); end
        rst = 1'b0;
        @(negedge clk);
        send_cmd(0, OP_WRITE, 16'h0044, 32'h01020304, 2'd3, 1'b0);
        total++; if (bus.exwe !== 1'b1 || bus.exa !== 16'h0044 || bus.exwd !== 32'h01020304) begin bad++; $display("[TB] FAIL post_rst_write: got we=%b a=%h d=%h want 1 0044 01020304", bus.exwe, bus.exa, bus.exwd); end
        @(negedge clk);
        total++; if (bus.exwe !== 1'b0 || bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL post_rst_idle: got we=%b v=%b want 0 0", bus.exwe, bus.rsp_valid); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = '0; bus.cmd_data = '0;
        bus.cmd_romul = '0; bus.cmd_bank = '0; bus.rsp_ready = 1'b0; bus.done = 1'b0;
        bus_to.cmd_valid = 1'b0; bus_to.cmd_op = 2'd0; bus_to.cmd_addr = '0; bus_to.cmd_data = '0;
        bus_to.cmd_romul = '0; bus_to.cmd_bank = '0; bus_to.rsp_ready = 1'b0; bus_to.done = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_reserved();
        test_run();
        test_spurious_done();
        test_timeout();
        test_done_on_timeout();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cma_host_ctrl.md
# cma_host_ctrl

Parametrised host-side sequencer for the CMA external port. It takes a stream of WRITE/READ/RUN commands over a valid/ready interface and drives the CMA external bus: exa/exwd/exwe/exre/exromul/cbank/run. For RUN it holds `run` until the array's `done` and reports a saturating cycle count with timeout detection. It replaces hand-sequenced host stimulus and supports multi-bank contexts, configurable read latency and a watchdog.

## Interface
- `DATA_W`, 32, external data width
- `EXA_W`, 16, external address width
- `ROMUL_W`, 2, ROMULTIC select width
- `BANK_W`, 1, bank select width (2^BANK_W context banks)
- `RD_LAT`, 2, cycles from `exre` to valid `exrd` (1..7)
- `CNT_W`, 24, run-cycle counter width
- `TIMEOUT`, 2^20, max run cycles before abort (0 = disabled)
- `clk` in 1, sole clock
- `rst` in 1, synchronous, active-high reset
- `cmd_valid` in 1, command present
- `cmd_ready` out 1, command accepted when both high
- `cmd_op` in 2, 0=WRITE, 1=READ, 2=RUN, 3=reserved (accepted, no action)
- `cmd_addr` in EXA_W, address (WRITE/READ)
- `cmd_data` in DATA_W, write data
- `cmd_romul` in ROMUL_W, ROMULTIC bits (WRITE/READ)
- `cmd_bank` in BANK_W, bank for RUN
- `rsp_valid` out 1, read data available
- `rsp_ready` in 1, read data consumed
- `rsp_data` out DATA_W, read data
- `exa` out EXA_W, `exwd` out DATA_W, `exromul` out ROMUL_W, `exwe` out 1, `exre` out 1
- `exrd` in DATA_W, CMA read data
- `cbank` out BANK_W, `run` out 1, `done` in 1
- `busy` out 1, state != IDLE
- `run_cycles` out CNT_W, cycles `run` was high in last RUN (saturating)
- `timeout_err` out 1, sticky; last RUN aborted by watchdog

## Operation
- States: IDLE, WR, RD, RSP, RUN.
- IDLE: `cmd_ready`=1. On accept, latch fields. WRITE→WR, READ→RD, RUN→RUN, reserved stays IDLE.
- WR: one cycle; `exwe`=1, `exa/exwd/exromul` = latched values; → IDLE.
- RD: `exre`=1 for first cycle only, `exa/exromul` held for whole state. After RD_LAT cycles, capture `exrd` into `rsp_data` and go → RSP.
- RSP: `rsp_valid`=1, data stable until `rsp_ready`. → IDLE on handshake.
- RUN: on entry, clear `run_cycles` and `timeout_err`; `cbank` = latched bank (held after RUN until next RUN); `run`=1.
- RUN counting: `run_cycles` increments each cycle `run`=1, saturating at all-ones.
- RUN exit: `done`=1 sampled → `run`=0 next cycle, → IDLE. Else, when count reaches TIMEOUT → set `timeout_err`, drop `run`, → IDLE.
- `done` same cycle as timeout: done wins, no error.
- `done` outside RUN is ignored.
- `exwe`/`exre`/`run` are never high together. Only one command is in flight at a time.

## Timing
- Reset: all outputs 0 (`cmd_ready`=0 during reset, 1 first cycle after), state IDLE, counters 0.
- Reset mid-operation: outputs 0 the edge after `rst`. No response is emitted, and `run` drops immediately.
- All outputs are registered.
- Command accepted at edge N → bus activity from cycle N+1.
- WRITE: `exwe` high exactly cycle N+1. Next accept at earliest edge N+2.
- READ: `exre` high cycle N+1. `exrd` sampled at end of cycle N+RD_LAT. `rsp_valid` rises at cycle N+RD_LAT+1.
- RUN: `run` rises cycle N+1. With `done` sampled at edge M, `run` is low from cycle M+1 and `run_cycles` = M−N.

## Structure
- Shared package `cma_host_pkg`: op encodings (OP_WRITE/OP_READ/OP_RUN), state enum, default widths matching the CMA external-port widths.
- One sub-module: `cma_run_watchdog`, containing the saturating counter, timeout compare and sticky error.

## Test plan
- WRITE addr 0x0010, data 0xDEADBEEF, romul 1 → `exwe` one cycle with exa=0x0010, exwd=0xDEADBEEF, exromul=1; `cmd_ready` low that cycle.
- READ addr 0x0020, RD_LAT=2, model returns 0x12345678 → `exre` one cycle; `rsp_data`=0x12345678. Hold `rsp_ready` low for 5 cycles → data stable, `cmd_ready`=0.
- RUN bank 1, `done` after 100 cycles → `cbank`=1, `run` high 100 cycles, `run_cycles`=100, `timeout_err`=0.
- RUN with TIMEOUT=50, `done` never asserted → `run` drops after 50 cycles, `timeout_err`=1. Next RUN clears it.
- `done` on the exact timeout cycle → no error. Spurious `done` while IDLE → no state change.
- `rst` asserted mid-RUN and mid-RSP → all outputs 0 next cycle, then clean WRITE succeeds.
